// File: rtl/icache_refill_if.sv
// Cache-side miss handshake, memory read port and block-fill bus of the refill engine.
// The master modport is the refill engine's view; slave is the cache/memory side.
interface icache_refill_if #(
    parameter int BLOCKSIZE = 4,
    parameter int ASSOC     = 2,
    parameter int SETS      = 2
);
    localparam int TAGW = 32 - SETS - BLOCKSIZE;
    localparam int BLKW = 1 << (BLOCKSIZE + 3);

    logic              miss_req;
    logic [31:0]       miss_addr;
    logic              mem_req;
    logic [31:0]       mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              fill_we;
    logic [ASSOC-1:0]  fill_way;
    logic [SETS-1:0]   fill_set;
    logic [TAGW-1:0]   fill_tag;
    logic [BLKW-1:0]   fill_block;
    logic              busy;
    logic              miss_done;

    modport master (
        input  miss_req, miss_addr, mem_ack, mem_rdata,
        output mem_req, mem_addr, fill_we, fill_way, fill_set, fill_tag,
               fill_block, busy, miss_done
    );

    modport slave (
        output miss_req, miss_addr, mem_ack, mem_rdata,
        input  mem_req, mem_addr, fill_we, fill_way, fill_set, fill_tag,
               fill_block, busy, miss_done
    );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache miss handler: fetches a block word by word, picks a victim way
// per set in round-robin order and writes the assembled block back in one pulse.
module icache_refill #(
    parameter int BLOCKSIZE = 4,
    parameter int ASSOC     = 2,
    parameter int SETS      = 2
) (
    input  logic             clk,
    input  logic             reset,
    icache_refill_if.master  bus
);
    localparam int W     = 1 << (BLOCKSIZE - 2);
    localparam int CNTW  = (W > 1) ? $clog2(W) : 1;
    localparam int RRW   = (ASSOC > 1) ? $clog2(ASSOC) : 1;
    localparam int NSETS = 1 << SETS;
    localparam int TAGW  = 32 - SETS - BLOCKSIZE;
    localparam int BLKW  = 32 * W;
    localparam logic [CNTW-1:0] LAST_WORD  = CNTW'(W - 1);
    localparam logic [31:0]     BLOCK_MASK = 32'((1 << BLOCKSIZE) - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNTW-1:0]   r_cnt;
    logic [31:0]       r_base;
    logic [SETS-1:0]   r_set;
    logic [TAGW-1:0]   r_tag;
    logic [SETS-1:0]   r_fill_set;
    logic [TAGW-1:0]   r_fill_tag;
    logic [ASSOC-1:0]  r_fill_way;
    logic [BLKW-1:0]   r_block;
    logic [RRW-1:0]    r_rr [NSETS];

    logic              w_ack;
    logic              w_last;
    logic [ASSOC-1:0]  w_victim;
    logic              w_mem_req;
    logic              w_busy;
    logic              w_fill;

    assign w_ack    = bus.mem_ack && (r_state == S_REQ);
    assign w_last   = (r_cnt == LAST_WORD);
    assign w_victim = {{(ASSOC-1){1'b0}}, 1'b1} << r_rr[r_set];

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every combinational output gets a default before the case so no
    // path through the process leaves it unassigned (which would infer a latch).
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.miss_req) w_next = S_REQ;
            S_REQ:   if (w_ack && w_last) w_next = S_FILL;
            S_FILL:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_mem_req = 1'b0;
        w_busy    = 1'b0;
        w_fill    = 1'b0;
        unique case (r_state)
            S_REQ: begin
                w_mem_req = 1'b1;
                w_busy    = 1'b1;
            end
            S_FILL: begin
                w_busy = 1'b1;
                w_fill = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: the block buffer and round-robin table are reset explicitly: the cache
    // relies on a defined victim order and a zeroed fill bus straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_base     <= '0;
            r_set      <= '0;
            r_tag      <= '0;
            r_fill_set <= '0;
            r_fill_tag <= '0;
            r_fill_way <= '0;
            r_block    <= '0;
            for (int i = 0; i < NSETS; i++) r_rr[i] <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.miss_req) begin
                        r_base <= bus.miss_addr & ~BLOCK_MASK;
                        r_set  <= bus.miss_addr[BLOCKSIZE+SETS-1:BLOCKSIZE];
                        r_tag  <= bus.miss_addr[31:BLOCKSIZE+SETS];
                        r_cnt  <= '0;
                    end
                end
                S_REQ: begin
                    if (bus.mem_ack) begin
                        r_block[{r_cnt, 5'd0} +: 32] <= bus.mem_rdata;
                        if (w_last) begin
                            // Fill-side outputs change only as the FILL cycle begins.
                            r_fill_way <= w_victim;
                            r_fill_set <= r_set;
                            r_fill_tag <= r_tag;
                        end else begin
                            r_cnt <= r_cnt + CNTW'(1);
                        end
                    end
                end
                S_FILL: r_rr[r_set] <= r_rr[r_set] + RRW'(1);
                default: ;
            endcase
        end
    end

    // Sub-block offset bits of the base are zero, so OR-ing the word offset never carries.
    assign bus.mem_addr   = r_base | 32'({r_cnt, 2'b00});
    assign bus.mem_req    = w_mem_req;
    assign bus.busy       = w_busy;
    assign bus.fill_we    = w_fill;
    assign bus.miss_done  = w_fill;
    assign bus.fill_way   = r_fill_way;
    assign bus.fill_set   = r_fill_set;
    assign bus.fill_tag   = r_fill_tag;
    assign bus.fill_block = r_block;
endmodule
